// File: rtl/alarm_pkg.sv
// alarm_pkg -- shared definitions for the alarm controller and its siren driver.
//   alarm_state_e : siren driver state encoding (3 bits)
//   DEF_*_TICKS   : default tick constants shared with the controller
//   cnt_width()   : width of a tick counter that must hold values 0..max_ticks-1
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOUND   = 3'd1,
    ST_HOLDOFF = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_CHIRP   = 3'd4
  } alarm_state_e;

  localparam int DEF_SOUND_TICKS   = 8;
  localparam int DEF_HOLDOFF_TICKS = 4;
  localparam int DEF_BLINK_TICKS   = 2;
  localparam int DEF_CHIRP_TICKS   = 1;
  localparam int DEF_MAX_ROUNDS    = 3;

  // A counter only ever holds 0..max_ticks-1; keep at least one bit so a
  // limit of a single tick still produces a legal vector.
  function automatic int cnt_width(input int max_ticks);
    return (max_ticks <= 1) ? 1 : $clog2(max_ticks);
  endfunction

endpackage

// File: rtl/alarm_siren_driver_tick_counter.sv
// tick_counter -- counts tick enables up to a terminal value.
//   clock, reset : clock and synchronous active-high reset
//   clear        : return the count to zero (wins over tick_en)
//   tick_en      : count this cycle
//   limit        : terminal count (number of ticks minus one)
//   done         : high in the cycle whose tick reaches the terminal count
// The count holds at the terminal value instead of wrapping; the owner is
// expected to clear it when done fires.
module tick_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         tick_en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    done  = tick_en && (cnt_q == limit);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick_en && (cnt_q != limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_siren_driver.sv
// alarm_siren_driver -- drives the siren and hazard lights from the alarm
// controller's request level (alarme) and disarm indication (desarmar).
// Bounds each siren round, inserts silent gaps between rounds, locks out after
// MAX_ROUNDS rounds and, when built with SIREN_CHIRP_EN defined, sounds a short
// acknowledgment chirp on disarm. Without SIREN_CHIRP_EN a disarm goes straight
// to IDLE.
//   clock, reset : clock and synchronous active-high reset
//   tick         : one-cycle time-base enable from the shared prescaler
//   alarme       : alarm request level
//   desarmar     : disarm indication, its rising edge is the event
//   siren        : siren drive
//   lights       : hazard-light drive
//   active       : high whenever the driver is not idle
//   round        : completed sound rounds since the last IDLE
// Interfaces are level/event based, no valid/ready handshake. All outputs are
// registered alongside the state, so every transition shows on the edge after
// the input that caused it.
module alarm_siren_driver
  import alarm_pkg::*;
#(
  parameter int SOUND_TICKS   = DEF_SOUND_TICKS,
  parameter int HOLDOFF_TICKS = DEF_HOLDOFF_TICKS,
  parameter int BLINK_TICKS   = DEF_BLINK_TICKS,
  parameter int CHIRP_TICKS   = DEF_CHIRP_TICKS,
  parameter int MAX_ROUNDS    = DEF_MAX_ROUNDS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       alarme,
  input  logic       desarmar,
  output logic       siren,
  output logic       lights,
  output logic       active,
  output logic [3:0] round
);

  localparam int MAX_TIMED = (SOUND_TICKS > HOLDOFF_TICKS)
                           ? ((SOUND_TICKS > CHIRP_TICKS) ? SOUND_TICKS : CHIRP_TICKS)
                           : ((HOLDOFF_TICKS > CHIRP_TICKS) ? HOLDOFF_TICKS : CHIRP_TICKS);
  localparam int TW = cnt_width(MAX_TIMED);
  localparam int BW = cnt_width(BLINK_TICKS);
  localparam logic [3:0] ROUND_MAX = 4'(MAX_ROUNDS);

`ifdef SIREN_CHIRP_EN
  localparam alarm_state_e DIS_TARGET = ST_CHIRP;
`else
  localparam alarm_state_e DIS_TARGET = ST_IDLE;
`endif

  alarm_state_e  state_q, state_d;
  logic          siren_q, siren_d;
  logic          lights_q, lights_d;
  logic          active_q, active_d;
  logic [3:0]    round_q, round_d;
  logic          desarmar_q;
  logic          dis_mask_q;

  logic          dis_ev;
  logic          entering;
  logic [TW-1:0] timer_limit;
  logic          timer_en, timer_done;
  logic          blink_clear, blink_en, blink_done;

  always_comb begin
    // dis_mask_q suppresses a desarmar level that was already high when reset
    // was released; it drops once desarmar goes low.
    dis_ev      = desarmar && !desarmar_q && !dis_mask_q;
    state_d     = state_q;
    round_d     = round_q;
    timer_limit = '0;
    timer_en    = 1'b0;

    case (state_q)
      ST_SOUND: begin
        timer_limit = TW'(SOUND_TICKS - 1);
        timer_en    = tick;
      end
      ST_HOLDOFF: begin
        timer_limit = TW'(HOLDOFF_TICKS - 1);
        timer_en    = tick;
      end
`ifdef SIREN_CHIRP_EN
      ST_CHIRP: begin
        timer_limit = TW'(CHIRP_TICKS - 1);
        timer_en    = tick;
      end
`endif
      default: ;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (dis_ev)      state_d = DIS_TARGET;
        else if (alarme) state_d = ST_SOUND;
      end
      ST_SOUND: begin
        if (dis_ev)       state_d = DIS_TARGET;
        else if (!alarme) state_d = ST_IDLE;
        else if (timer_done) begin
          round_d = (round_q >= ROUND_MAX) ? ROUND_MAX : round_q + 4'd1;
          state_d = (round_d == ROUND_MAX) ? ST_LOCKOUT : ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (dis_ev)          state_d = DIS_TARGET;
        else if (!alarme)    state_d = ST_IDLE;
        else if (timer_done) state_d = ST_SOUND;
      end
      ST_LOCKOUT: begin
        if (dis_ev)       state_d = DIS_TARGET;
        else if (!alarme) state_d = ST_IDLE;
      end
`ifdef SIREN_CHIRP_EN
      ST_CHIRP: begin
        if (timer_done) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_IDLE) || (state_d == ST_CHIRP)) round_d = 4'd0;

    // Any state change restarts both timers, which also discards a tick that
    // coincides with the transition.
    entering    = (state_d != state_q);
    blink_en    = tick && (state_q == ST_SOUND);
    blink_clear = entering || blink_done;

    siren_d  = (state_d == ST_SOUND) || (state_d == ST_CHIRP);
    active_d = (state_d != ST_IDLE);
    case (state_d)
      ST_SOUND:   lights_d = entering ? 1'b1 : (blink_done ? !lights_q : lights_q);
      ST_LOCKOUT: lights_d = 1'b1;
      ST_CHIRP:   lights_d = 1'b1;
      default:    lights_d = 1'b0;
    endcase
  end

  tick_counter #(.W(TW)) u_state_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (entering),
    .tick_en (timer_en),
    .limit   (timer_limit),
    .done    (timer_done)
  );

  tick_counter #(.W(BW)) u_blink_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (blink_clear),
    .tick_en (blink_en),
    .limit   (BW'(BLINK_TICKS - 1)),
    .done    (blink_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      siren_q    <= 1'b0;
      lights_q   <= 1'b0;
      active_q   <= 1'b0;
      round_q    <= 4'd0;
      desarmar_q <= 1'b0;
      dis_mask_q <= desarmar;
    end else begin
      state_q    <= state_d;
      siren_q    <= siren_d;
      lights_q   <= lights_d;
      active_q   <= active_d;
      round_q    <= round_d;
      desarmar_q <= desarmar;
      dis_mask_q <= dis_mask_q && desarmar;
    end
  end

  assign siren  = siren_q;
  assign lights = lights_q;
  assign active = active_q;
  assign round  = round_q;

endmodule

// File: tb/tb_alarm_siren_driver.sv
// tb_alarm_siren_driver -- self-checking bench for alarm_siren_driver with
// default parameters and a tick every 4 clocks. A reference model predicts
// {siren, lights, active, round} for each driven cycle; the prediction is
// queued and compared after the clock edge. Chirp expectations follow
// SIREN_CHIRP_EN.
module tb_alarm_siren_driver;

  localparam int S = 8;
  localparam int H = 4;
  localparam int B = 2;
  localparam int C = 1;
  localparam int M = 3;
`ifdef SIREN_CHIRP_EN
  localparam int DIS_ST = 4;
`else
  localparam int DIS_ST = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       alarme = 1'b0;
  logic       desarmar = 1'b0;
  logic       siren, lights, active;
  logic [3:0] round;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [6:0] exp_q[$];

  // reference model state: 0 idle, 1 sound, 2 holdoff, 3 lockout, 4 chirp
  int m_st = 0, m_cnt = 0, m_bcnt = 0, m_rnd = 0;
  bit m_lt = 0, m_dq = 0, m_hold = 0;

  alarm_siren_driver dut (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .alarme   (alarme),
    .desarmar (desarmar),
    .siren    (siren),
    .lights   (lights),
    .active   (active),
    .round    (round)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task model_step(input bit r, input bit t, input bit a, input bit d);
    bit ev, tog;
    int nxt, nr;
    if (r) begin
      m_st = 0; m_cnt = 0; m_bcnt = 0; m_lt = 0; m_rnd = 0; m_dq = 0; m_hold = d;
    end else begin
      ev     = d && !m_dq && !m_hold;
      m_hold = m_hold && d;
      m_dq   = d;
      nxt    = m_st;
      nr     = m_rnd;
      tog    = 0;
      case (m_st)
        0: if (ev) nxt = DIS_ST; else if (a) nxt = 1;
        1: begin
          if (ev) nxt = DIS_ST;
          else if (!a) nxt = 0;
          else if (t) begin
            if (m_cnt == S - 1) begin
              nr  = (m_rnd < M) ? m_rnd + 1 : M;
              nxt = (nr == M) ? 3 : 2;
            end else m_cnt++;
            if (m_bcnt == B - 1) begin m_bcnt = 0; tog = 1; end else m_bcnt++;
          end
        end
        2: begin
          if (ev) nxt = DIS_ST;
          else if (!a) nxt = 0;
          else if (t) begin
            if (m_cnt == H - 1) nxt = 1; else m_cnt++;
          end
        end
        3: if (ev) nxt = DIS_ST; else if (!a) nxt = 0;
        default: if (t) begin
          if (m_cnt == C - 1) nxt = 0; else m_cnt++;
        end
      endcase
      if (nxt != m_st) begin
        m_cnt = 0; m_bcnt = 0;
        m_lt  = (nxt == 1) || (nxt == 3) || (nxt == 4);
      end else if (tog) begin
        m_lt = !m_lt;
      end
      if ((nxt == 0) || (nxt == 4)) nr = 0;
      m_rnd = nr;
      m_st  = nxt;
    end
  endtask

  function automatic logic [6:0] model_out();
    logic s;
    s = (m_st == 1) || (m_st == 4);
    return {s, m_lt, (m_st != 0), 4'(m_rnd)};
  endfunction

  // driver: one clock of stimulus, prediction queued, DUT compared after edge
  task automatic step(input string tag, input bit r, input bit a, input bit d);
    logic [6:0] exp;
    reset    = r;
    alarme   = a;
    desarmar = d;
    tick     = ((cyc % 4) == 3);
    model_step(r, tick, a, d);
    exp_q.push_back(model_out());
    @(posedge clock);
    #1;
    cyc++;
    exp = exp_q.pop_front();
    check(tag, {siren, lights, active, round}, exp);
  endtask

  task automatic run(input string tag, input int n, input bit r, input bit a, input bit d);
    for (int i = 0; i < n; i++) step(tag, r, a, d);
  endtask

  initial begin
    logic [1:0] dis_exp;
    bit a, d, r;

    // reset state
    run("reset", 3, 1, 0, 0);
    check("rst_outputs", {siren, lights, active, round}, 7'd0);

    // rounds, blink, holdoff, lockout
    run("sound1", 1, 0, 1, 0);
    check("sound_entry", {siren, lights, active, round}, 7'b1110000);
    run("rounds", 180, 0, 1, 0);
    check("lock_round", round, 4'd3);
    check("lock_out", {siren, lights, active}, 3'b011);
    run("lock_hold", 20, 0, 1, 0);
    check("lock_steady", {siren, lights, round}, 6'b010011);
    run("lock_exit", 4, 0, 0, 0);
    check("lock_idle", {active, round}, 5'd0);

    // disarm mid-SOUND, held high
    run("reset", 2, 1, 0, 0);
    run("sound2", 13, 0, 1, 0);
    step("dis_edge", 0, 1, 1);
`ifdef SIREN_CHIRP_EN
    dis_exp = 2'b11;
`else
    dis_exp = 2'b00;
`endif
    check("dis_next", {siren, lights}, dis_exp);
    run("dis_held", 30, 0, 1, 1);
    run("dis_low", 10, 0, 0, 0);

    // alarme and disarm arrive together in IDLE
    step("both_idle", 0, 1, 1);
    run("both_after", 12, 0, 1, 1);
    run("both_end", 4, 0, 0, 0);

    // reset during HOLDOFF
    run("to_holdoff", 40, 0, 1, 0);
    step("rst_mid", 1, 1, 0);
    check("rst_drop", {siren, lights, active, round}, 7'd0);
    run("post_rst", 12, 0, 0, 0);
    check("post_rst_idle", active, 1'b0);

    // desarmar high across reset release is not an event
    run("rst_dis", 2, 1, 0, 1);
    run("dis_at_rel", 12, 0, 0, 1);
    check("no_dis_ev", active, 1'b0);
    run("dis_rel_low", 2, 0, 0, 0);

    // random traffic
    a = 0; d = 0; r = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) a = !a;
      if ($urandom_range(0, 9) == 0) d = !d;
      r = ($urandom_range(0, 299) == 0);
      step("random", r, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
